// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry and FSM encoding for the instruction cache
package icache_pkg;

  localparam int ICACHE_INDEX_WIDTH  = 4;
  localparam int ICACHE_OFFSET_WIDTH = 2;
  localparam int ICACHE_TAG_WIDTH    = 32 - 2 - ICACHE_OFFSET_WIDTH - ICACHE_INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REFILL   = 2'd1,
    RESPOND  = 2'd2,
    COOLDOWN = 2'd3
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetcher and memory-controller signal bundle for the instruction cache
interface icache_if;

  logic        rdy_in;
  logic        flush_in;
  logic        query_en;
  logic [31:0] query_pc;
  logic        data_en;
  logic [31:0] addr_confirm;
  logic [31:0] data;
  logic        mem_req_en;
  logic [31:0] mem_req_addr;
  logic        mem_data_en;
  logic [31:0] mem_data;

  modport slave (
    input  rdy_in, flush_in, query_en, query_pc, mem_data_en, mem_data,
    output data_en, addr_confirm, data, mem_req_en, mem_req_addr
  );

  modport master (
    output rdy_in, flush_in, query_en, query_pc, mem_data_en, mem_data,
    input  data_en, addr_confirm, data, mem_req_en, mem_req_addr
  );

endinterface

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - tag, valid and word storage; sync write, combinational read
module icache_data_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH  = ICACHE_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = ICACHE_TAG_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    inv_all_ni,
  input  logic [INDEX_WIDTH-1:0]  idx_i,
  input  logic [OFFSET_WIDTH-1:0] rd_off_i,
  input  logic [OFFSET_WIDTH-1:0] wr_off_i,
  input  logic                    word_we_i,
  input  logic [31:0]             wr_word_i,
  input  logic                    line_inv_i,
  input  logic                    line_fill_i,
  input  logic [TAG_WIDTH-1:0]    fill_tag_i,
  output logic [31:0]             rd_word_o,
  output logic [TAG_WIDTH-1:0]    rd_tag_o,
  output logic                    rd_valid_o
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [31:0]          word_q [LINES][WORDS];

  // Only the valid bits need clearing; stale tags/words are harmless behind them.
  always_ff @(posedge clk_i or negedge inv_all_ni) begin
    if (!inv_all_ni) begin
      valid_q <= '0;
    end else if (line_inv_i) begin
      valid_q[idx_i] <= 1'b0;
    end else if (line_fill_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (word_we_i) begin
      word_q[idx_i][wr_off_i] <= wr_word_i;
    end
    if (line_fill_i) begin
      tag_q[idx_i] <= fill_tag_i;
    end
  end

  assign rd_word_o  = word_q[idx_i][rd_off_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_valid_o = valid_q[idx_i];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with sequential line refill
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH  = ICACHE_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH,
  localparam int TAG_WIDTH   = 32 - 2 - OFFSET_WIDTH - INDEX_WIDTH
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  icache_if.slave  bus
);

  localparam int LO = OFFSET_WIDTH + 2;

  icache_state_e           state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  logic                    flushed_q, flushed_d;
  logic                    data_en_q, data_en_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic                    req_en_q, req_en_d;
  logic [31:0]             req_addr_q, req_addr_d;

  logic [31:2]             sel_pc;
  logic [31:0]             rd_word;
  logic [TAG_WIDTH-1:0]    rd_tag;
  logic                    rd_valid, hit, last_word;
  logic                    word_we, line_inv, line_fill;

  // IDLE looks up the live query; every later state works on the latched pc.
  assign sel_pc    = (state_q == IDLE) ? bus.query_pc[31:2] : pc_q[31:2];
  assign hit       = rd_valid && (rd_tag == sel_pc[31 -: TAG_WIDTH]);
  assign last_word = &cnt_q;
  assign cnt_nxt   = cnt_q + 1'b1;

  icache_data_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk_i      (clk_in),
    .inv_all_ni (rst_n_in),
    .idx_i      (sel_pc[LO +: INDEX_WIDTH]),
    .rd_off_i   (sel_pc[2 +: OFFSET_WIDTH]),
    .wr_off_i   (cnt_q),
    .word_we_i  (word_we && bus.rdy_in),
    .wr_word_i  (bus.mem_data),
    .line_inv_i (line_inv && bus.rdy_in),
    .line_fill_i(line_fill && bus.rdy_in),
    .fill_tag_i (sel_pc[31 -: TAG_WIDTH]),
    .rd_word_o  (rd_word),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    data_en_d  = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    req_en_d   = req_en_q;
    req_addr_d = req_addr_q;
    word_we    = 1'b0;
    line_inv   = 1'b0;
    line_fill  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.query_en && !bus.flush_in) begin
          pc_d = bus.query_pc;
          if (hit) begin
            data_en_d = 1'b1;
            addr_d    = bus.query_pc;
            data_d    = rd_word;
            state_d   = COOLDOWN;
          end else begin
            line_inv   = 1'b1;
            cnt_d      = '0;
            flushed_d  = 1'b0;
            req_en_d   = 1'b1;
            req_addr_d = {bus.query_pc[31:LO], {OFFSET_WIDTH{1'b0}}, 2'b00};
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        if (bus.flush_in) begin
          flushed_d = 1'b1;
        end
        if (bus.mem_data_en) begin
          word_we = 1'b1;
          cnt_d   = cnt_nxt;
          if (last_word) begin
            req_en_d  = 1'b0;
            line_fill = 1'b1;
            state_d   = (flushed_q || bus.flush_in) ? IDLE : RESPOND;
          end else begin
            req_addr_d = {pc_q[31:LO], cnt_nxt, 2'b00};
          end
        end
      end
      RESPOND: begin
        if (bus.flush_in) begin
          state_d = IDLE;
        end else begin
          data_en_d = 1'b1;
          addr_d    = pc_q;
          data_d    = rd_word;
          state_d   = COOLDOWN;
        end
      end
      COOLDOWN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      data_en_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      req_en_q   <= 1'b0;
      req_addr_q <= '0;
    end else if (bus.rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
      data_en_q  <= data_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      req_en_q   <= req_en_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign bus.data_en      = data_en_q;
  assign bus.addr_confirm = addr_q;
  assign bus.data         = data_q;
  assign bus.mem_req_en   = req_en_q;
  assign bus.mem_req_addr = req_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache with a fixed-latency memory
module tb_icache;

  localparam int MEM_LAT  = 2;
  localparam int MISS_LAT = 2 + 4 * MEM_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  icache_if bus ();

  icache dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int mem_wait = 0;
  int base_resp = 0;
  int base_req = 0;
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory answers each held request MEM_LAT cycles later; also counts response pulses.
  initial begin
    bus.mem_data_en = 1'b0;
    bus.mem_data    = '0;
    forever begin
      @(negedge clk);
      if (bus.data_en) resp_cnt++;
      bus.mem_data_en = 1'b0;
      if (!rst_n) begin
        mem_wait = 0;
      end else if (bus.mem_req_en) begin
        if (mem_wait == MEM_LAT - 1) begin
          bus.mem_data_en = 1'b1;
          bus.mem_data    = mem_word(bus.mem_req_addr);
          req_log.push_back(bus.mem_req_addr);
          mem_wait = 0;
        end else begin
          mem_wait++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic start_query(input logic [31:0] pc);
    bus.query_pc = pc;
    bus.query_en = 1'b1;
    base_resp    = resp_cnt;
    base_req     = req_log.size();
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.data_en && n < 60);
    check_eq("resp_seen", 32'(bus.data_en), 32'd1);
  endtask

  task automatic finish_query(input string tag);
    tick();
    bus.query_en = 1'b0;
    tick();
    tick();
    check_eq({tag, "_nresp"}, 32'(resp_cnt - base_resp), 32'd1);
  endtask

  task automatic do_query(input string tag, input logic [31:0] pc, input int exp_lat,
                          input logic [31:0] exp_data);
    int n;
    start_query(pc);
    wait_resp(n);
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_data"}, bus.data, exp_data);
    check_eq({tag, "_addr"}, bus.addr_confirm, pc);
    finish_query(tag);
  endtask

  initial begin
    int n;
    bus.rdy_in   = 1'b1;
    bus.flush_in = 1'b0;
    bus.query_en = 1'b0;
    bus.query_pc = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_data_en", 32'(bus.data_en), 32'd0);
    check_eq("rst_addr_confirm", bus.addr_confirm, 32'd0);
    check_eq("rst_data", bus.data, 32'd0);
    check_eq("rst_mem_req_en", 32'(bus.mem_req_en), 32'd0);
    check_eq("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    do_query("cold", 32'h8, MISS_LAT, 32'hA2);
    for (int i = 0; i < 4; i++) check_eq("cold_req_addr", req_log[i], 32'(i * 4));

    do_query("hit_c", 32'hC, 1, 32'hA3);
    check_eq("hit_c_noreq", 32'(req_log.size() - base_req), 32'd0);
    do_query("b2b_0", 32'h0, 1, 32'hA0);
    do_query("b2b_4", 32'h4, 1, 32'hA1);

    do_query("evict", 32'h100, MISS_LAT, 32'hE0);
    check_eq("evict_req0", req_log[base_req], 32'h100);
    do_query("remiss", 32'h0, MISS_LAT, 32'hA0);

    start_query(32'hC);
    bus.flush_in = 1'b1;
    repeat (2) tick();
    bus.query_en = 1'b0;
    bus.flush_in = 1'b0;
    repeat (2) tick();
    check_eq("idle_flush_nresp", 32'(resp_cnt - base_resp), 32'd0);

    start_query(32'h40);
    repeat (4) tick();
    bus.flush_in = 1'b1;
    bus.query_en = 1'b0;
    tick();
    bus.flush_in = 1'b0;
    repeat (10) tick();
    check_eq("mid_flush_nresp", 32'(resp_cnt - base_resp), 32'd0);
    check_eq("mid_flush_nreq", 32'(req_log.size() - base_req), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("mid_flush_req", req_log[base_req + i], 32'(32'h40 + i * 4));
    do_query("after_flush", 32'h44, 1, 32'hB1);

    start_query(32'h80);
    repeat (8) tick();
    bus.flush_in = 1'b1;
    bus.query_en = 1'b0;
    tick();
    bus.flush_in = 1'b0;
    repeat (4) tick();
    check_eq("last_flush_nresp", 32'(resp_cnt - base_resp), 32'd0);
    check_eq("last_flush_nreq", 32'(req_log.size() - base_req), 32'd4);
    do_query("last_flush_hit", 32'h8C, 1, 32'hC3);

    start_query(32'hC0);
    repeat (3) tick();
    check_eq("rdy_pre_addr", bus.mem_req_addr, 32'hC4);
    bus.rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rdy_hold_req_en", 32'(bus.mem_req_en), 32'd1);
      check_eq("rdy_hold_addr", bus.mem_req_addr, 32'hC4);
    end
    bus.rdy_in = 1'b1;
    wait_resp(n);
    check_eq("rdy_lat", 32'(6 + n), 32'(MISS_LAT + 2));
    check_eq("rdy_data", bus.data, 32'hD0);
    check_eq("rdy_addr", bus.addr_confirm, 32'hC0);
    finish_query("rdy");

    start_query(32'h200);
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    bus.query_en = 1'b0;
    #1;
    check_eq("arst_req_en", 32'(bus.mem_req_en), 32'd0);
    check_eq("arst_req_addr", bus.mem_req_addr, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_query("arst_requery", 32'h200, MISS_LAT, 32'h120);
    do_query("arst_cold", 32'hC, MISS_LAT, 32'hA3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the memory controller and the instruction fetcher.
- Serves one word-aligned fetch query at a time.
  - Hits respond one cycle after the query is sampled.
  - Misses refill a whole line word-by-word from the memory controller, then respond.
- A flush from mispredict recovery cancels any response still owed to the fetcher.

Parameters:
- INDEX_WIDTH, 4, log2 of line count (16 lines).
- OFFSET_WIDTH, 2, log2 of words per line (4 words = 16 bytes).
- TAG_WIDTH, 32-2-OFFSET_WIDTH-INDEX_WIDTH (24), tag bits per line. Derived; do not override.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; low freezes all state
- flush_in  in  1  mispredict flush
- query_en  in  1  fetcher query valid, held until answered
- query_pc  in  32  fetch address; bits [1:0] ignored
- data_en  out  1  one-cycle response pulse
- addr_confirm  out  32  query_pc the response belongs to
- data  out  32  instruction word
- mem_req_en  out  1  word read request, held until mem_data_en
- mem_req_addr  out  32  word address requested
- mem_data_en  in  1  memory word valid, one-cycle pulse
- mem_data  in  32  memory word

Behaviour:
- Reset, asynchronous on rst_n_in low:
  - all valid bits cleared; state=IDLE.
  - data_en=0, addr_confirm=0, data=0, mem_req_en=0, mem_req_addr=0.
  - Reset mid-refill abandons the refill; the partial line stays invalid.
- rdy_in=0: no register changes; outputs hold.
- Address split: offset=pc[OFFSET_WIDTH+1:2]; index=next INDEX_WIDTH bits; tag=remaining upper bits.
- States: IDLE, REFILL, RESPOND, COOLDOWN.
- IDLE, query_en=1 and flush_in=0:
  - Latch query_pc.
  - Hit (valid[index] and tag match): data_en=1 next cycle with stored word, addr_confirm=query_pc; go to COOLDOWN.
  - Miss: valid[index]<=0, word counter<=0, mem_req_en<=1, mem_req_addr<={pc[31:OFFSET_WIDTH+2], counter, 2'b00}; go to REFILL.
- REFILL:
  - On mem_data_en: write mem_data to line word[counter], increment counter.
  - If counter was not the last word: next request address issued the following cycle; mem_req_en stays 1.
  - On the last word: mem_req_en<=0, write tag, valid<=1, go to RESPOND.
- RESPOND: data_en<=1 with the latched word and pc; go to COOLDOWN.
- COOLDOWN:
  - data_en<=0; any query is ignored this cycle, because the fetcher drops query_en one cycle after seeing data_en.
  - Return to IDLE.
- data_en is only ever a single-cycle pulse; at most one response per accepted query.
- flush_in:
  - IDLE: the query in that cycle is ignored (flush wins).
  - REFILL: the refill runs to completion (memory transactions are not aborted) and the line becomes valid; the response is suppressed and the block goes to IDLE, not RESPOND.
  - RESPOND: data_en is not asserted.
  - A pulse already on data_en is not retracted.
- Simultaneous mem_data_en and flush_in on the last word: the line is written valid, no response.
- Refill word order: starts at offset 0 and is sequential; the critical word is not prioritised.
- Hit latency 1 cycle.
- Miss latency: 2^OFFSET_WIDTH memory round trips plus 2 cycles.

Decomposition:
- Shared package: state encoding localparams (IDLE/REFILL/RESPOND/COOLDOWN) and the address-split helper widths.
- One sub-module, icache_data_array:
  - Holds the tag, valid and data storage.
  - Synchronous write, combinational read by index/offset.
  - Includes an invalidate-all input driven by reset.

Test Plan:
- Cold miss:
  - Stimulus: query 0x00000008, memory returns 0xA0,0xA1,0xA2,0xA3 for 0x0,0x4,0x8,0xC (2-cycle memory).
  - Required: mem_req_addr sequence 0x0,0x4,0x8,0xC; then a single data_en pulse with data=0xA2, addr_confirm=0x8.
- Hit after fill:
  - Stimulus: query 0x0000000C.
  - Required: data_en one cycle after sampling, data=0xA3; no mem_req_en.
- Conflict eviction:
  - Stimulus: query 0x00000100 (same index 0, different tag).
  - Required: refill from 0x100; a later query 0x0 misses again.
- Flush mid-refill:
  - Stimulus: flush_in during the second memory word of a query at 0x40.
  - Required: all four words still fetched; no data_en; a following query 0x44 hits in 1 cycle.
- Back-to-back queries:
  - Stimulus: fetcher-style query held until data_en, then a new pc.
  - Required: exactly one data_en per query; the COOLDOWN cycle ignores the stale query.
- Reset and rdy:
  - Stimulus: rst_n_in low mid-refill.
  - Required: mem_req_en drops immediately; the re-query misses.
  - Stimulus: rdy_in low for 3 cycles during REFILL.
  - Required: counter and outputs frozen.
